// File: rtl/ps2_key_event_queue.sv
// Turns held-key samples from the keyboard stage into make/break events and queues them.
// Events appear at ev_valid one edge after enqueue; ev_valid/ev_ready handshake; a push while full is dropped and flagged.
module ps2_key_event_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     reset_n,
  input  logic [7:0]               keyCode,
  input  logic                     press,
  input  logic                     ev_ready,
  input  logic                     clr_ovf,
  output logic                     ev_valid,
  output logic                     ev_make,
  output logic [7:0]               ev_code,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic {IDLE, PEND_MAKE} state_t;

  state_t       state, state_nxt;
  logic [7:0]   prev_code;
  logic         prev_press;
  logic [8:0]   pending;
  logic         make_det, brk_det;
  logic         push, pend_load;
  logic [8:0]   push_dat;

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [PW:0]   count_nxt, occ_after_pop;
  logic          pop, full, push_ok, drop;
  logic          head_vld_nxt;
  logic [8:0]    head_nxt;

  always_comb begin
    make_det = press && (keyCode != 8'h00) && (!prev_press || (keyCode != prev_code));
    brk_det  = prev_press && (!press || (keyCode != prev_code));
  end

  // A rollover yields two events; the make waits one cycle in 'pending'.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_dat  = 9'h000;
    pend_load = 1'b0;
    case (state)
      IDLE: begin
        if (brk_det) begin
          push     = 1'b1;
          push_dat = {1'b0, prev_code};
          if (make_det) begin
            pend_load = 1'b1;
            state_nxt = PEND_MAKE;
          end
        end else if (make_det) begin
          push     = 1'b1;
          push_dat = {1'b1, keyCode};
        end
      end
      PEND_MAKE: begin
        push      = 1'b1;
        push_dat  = pending;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      prev_code  <= 8'h00;
      prev_press <= 1'b0;
      pending    <= 9'h000;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        prev_code  <= keyCode;
        prev_press <= press;
      end
      if (pend_load)
        pending <= {1'b1, keyCode};
    end
  end

  always_comb begin
    pop     = ev_valid && ev_ready;
    full    = (count == CNT_MAX);
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    rd_nxt  = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
    occ_after_pop = pop ? (count - CNT_ONE) : count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Next head: empty stays stale, a push into an empty queue becomes the head directly.
  always_comb begin
    head_vld_nxt = (count_nxt != '0);
    head_nxt     = {ev_make, ev_code};
    if (head_vld_nxt) begin
      if (occ_after_pop == '0)
        head_nxt = push_dat;
      else
        head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ev_valid <= 1'b0;
      ev_make  <= 1'b0;
      ev_code  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr   <= rd_nxt;
      count    <= count_nxt;
      ev_valid <= head_vld_nxt;
      {ev_make, ev_code} <= head_nxt;
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: doc/ps2_key_event_queue.md
PS2_KEY_EVENT_QUEUE -- requirements
Module: ps2_key_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entry count (power of two, 2..16).
REQ-002 SHALL have port Clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port keyCode  input  8  current make code from the keyboard stage; 8'h00 when no key is held.
REQ-005 SHALL have port press  input  1  key-held flag from the keyboard stage.
REQ-006 SHALL have port ev_ready  input  1  consumer accepts the head event.
REQ-007 SHALL have port clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-008 SHALL have port ev_valid  output  1  FIFO not empty; head event present.
REQ-009 SHALL have port ev_make  output  1  head event type: 1 = make (press), 0 = break (release).
REQ-010 SHALL have port ev_code  output  8  head event key code.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of stored events.
REQ-012 SHALL have port overflow  output  1  sticky flag; an event was dropped.

Function
REQ-013 SHALL hold registers prev_code[7:0] and prev_press, sampled from the inputs.
REQ-014 SHALL detect make when press=1 and keyCode!=0 and (prev_press=0 or keyCode!=prev_code).
REQ-015 SHALL detect break when prev_press=1 and (press=0 or keyCode!=prev_code); the break carries prev_code.
REQ-016 SHALL implement a two-state FSM: IDLE, PEND_MAKE.
REQ-017 In IDLE, only break detected -> enqueue {0,prev_code}; only make detected -> enqueue {1,keyCode}; state stays IDLE.
REQ-018 In IDLE, break and make both detected -> enqueue {0,prev_code} this cycle, latch {1,keyCode} into a pending register, go to PEND_MAKE.
REQ-019 In PEND_MAKE, enqueue the pending make and return to IDLE unconditionally; detection is suppressed for that cycle.
REQ-020 SHALL update prev_code/prev_press from the inputs on every IDLE cycle and hold them in PEND_MAKE, so that input changes during PEND_MAKE are detected on the following IDLE cycle.
REQ-021 SHALL produce no event when press=1 with keyCode=0, or when inputs are unchanged (typematic repeat produces nothing).
REQ-022 SHALL store events in a DEPTH-entry, 9-bit, first-word-fall-through FIFO with wrapping read/write pointers.
REQ-023 ev_valid, ev_make and ev_code SHALL be driven directly from registered head state; ev_make/ev_code are don't-care while ev_valid=0.
REQ-024 Pop SHALL occur on a cycle with ev_valid=1 and ev_ready=1; ev_ready with ev_valid=0 has no effect.
REQ-025 Latency: an event enqueued at edge N SHALL make ev_valid=1 after edge N when the FIFO was empty; there is no same-cycle bypass.
REQ-026 A push while count=DEPTH and no pop in the same cycle SHALL drop the event, leave the pointers unchanged and set overflow.
REQ-027 A push and pop in the same cycle while full SHALL both succeed; count remains DEPTH.
REQ-028 A push and pop in the same cycle while not full and not empty SHALL leave count unchanged.
REQ-029 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or fall below 0.
REQ-030 overflow SHALL clear on clr_ovf=1; if clr_ovf and a drop occur in the same cycle, overflow SHALL be 1.

Reset
REQ-031 reset_n=0 SHALL asynchronously set: state=IDLE, prev_code=0, prev_press=0, pending=0, pointers=0, count=0, ev_valid=0, ev_make=0, ev_code=0, overflow=0.
REQ-032 Reset asserted mid-operation SHALL discard all stored and pending events; the first cycle after release SHALL evaluate detection against prev_press=0.

Verification
REQ-033 Press: keyCode=8'h1D, press=1 for 1 cycle, then hold -> exactly one event {make=1, code=1D}; ev_valid=1 one edge later.
REQ-034 Release: from 1D held, set press=0, keyCode=0 -> one event {0,1D}; with ev_ready=1 the FIFO empties and count=0.
REQ-035 Rollover: with 1D held, change keyCode to 8'h1C and keep press=1 -> events {0,1D} then {1,1C} on consecutive edges, visiting PEND_MAKE once.
REQ-036 Overflow: ev_ready=0, generate 9 events -> count=8, overflow=1, head={1st event}; pop one while pushing one -> count stays 8; pulse clr_ovf -> overflow=0.
REQ-037 Reset: 3 events queued and PEND_MAKE active, pulse reset_n low -> ev_valid=0, count=0 immediately; with press=1 and keyCode=1D after release -> make {1,1D} enqueued.
REQ-038 Null: press=1 with keyCode=0 for 10 cycles -> no events, count=0.
